// File: rtl/ps2_kbd_tx_if.sv
// AXI4 slave-side bundle for the PS/2 keyboard transmitter.
// Signals are grouped by channel: aw, w, b, ar, r.
interface ps2_kbd_tx_if;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              awready;
    logic              awvalid;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wready;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    logic              arready;
    logic              arvalid;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport slave (
        output awready, input awvalid, awid, awaddr, awlen, awsize, awburst,
        output wready,  input wvalid, wdata, wstrb, wlast,
        output bvalid, bresp, bid, input bready,
        output arready, input arvalid, arid, araddr, arlen, arsize, arburst,
        output rvalid, rdata, rresp, rlast, rid, input rready
    );

    modport master (
        input  awready, output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wready,  output wvalid, wdata, wstrb, wlast,
        input  bvalid, bresp, bid, output bready,
        input  arready, output arvalid, arid, araddr, arlen, arsize, arburst,
        input  rvalid, rdata, rresp, rlast, rid, output rready
    );
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: AXI4 writes queue scan codes in an 8-deep FIFO,
// each code is sent as an 11-bit device-to-host frame; AXI4 reads return status.
module ps2_kbd_tx #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned GAP     = 16
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        ps2_clk,
    output logic        ps2_dat,
    ps2_kbd_tx_if.slave io_slave
);
    localparam int unsigned DIV_W   = 9;
    localparam int unsigned PTR_W   = 3;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned COUNT_W = 4;
    localparam int unsigned FRAME_W = 11;

    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} w_state_t;
    typedef enum logic       {RIDLE, RDATA}        r_state_t;
    typedef enum logic [1:0] {TIDLE, TBIT, TGAP}   tx_state_t;

    w_state_t  w_state_q,  w_state_d;
    r_state_t  r_state_q,  r_state_d;
    tx_state_t tx_state_q, tx_state_d;

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               clk_q, clk_d, dat_q, dat_d;
    logic               awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]         bresp_q, bresp_d;
    logic [3:0]         bid_q, bid_d, rid_q, rid_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               push, pop, full, empty, busy;
    logic [7:0]         rd_data;
    logic [63:0]        status;

    assign full    = (count_q == COUNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign busy    = (tx_state_q != TIDLE);
    assign rd_data = mem[rd_ptr_q];
    assign status  = {55'd0, busy, 2'b00, empty, full, count_q};

    // Next-state and next-output logic for the write, read and transmit FSMs.
    always_comb begin
        w_state_d  = w_state_q;
        r_state_d  = r_state_q;
        tx_state_d = tx_state_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        clk_d      = clk_q;
        dat_d      = dat_q;
        push       = 1'b0;
        pop        = 1'b0;

        case (w_state_q)
            WIDLE: if (io_slave.awvalid) begin
                bid_d     = io_slave.awid;
                w_state_d = WDATA;
            end
            WDATA: if (io_slave.wvalid) begin
                push      = io_slave.wstrb[0] && !full;
                bresp_d   = push ? 2'd0 : 2'd2;
                w_state_d = WRESP;
            end
            WRESP:   if (io_slave.bready) w_state_d = WIDLE;
            default: w_state_d = WIDLE;
        endcase

        case (r_state_q)
            RIDLE: if (io_slave.arvalid) begin
                rid_d     = io_slave.arid;
                rdata_d   = status;
                r_state_d = RDATA;
            end
            RDATA:   if (io_slave.rready) r_state_d = RIDLE;
            default: r_state_d = RIDLE;
        endcase

        // Each bit: CLK_DIV cycles high (data changes on the first), then CLK_DIV low.
        case (tx_state_q)
            TIDLE: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_d    = {1'b1, ~^rd_data, rd_data, 1'b0};
                    dat_d      = 1'b0;
                    div_d      = '0;
                    bit_d      = '0;
                    tx_state_d = TBIT;
                end
            end
            TBIT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    clk_d = 1'b0;
                    div_d = div_q + DIV_W'(1);
                end else if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
                    div_d = '0;
                    clk_d = 1'b1;
                    if (bit_q == 4'd10) begin
                        dat_d      = 1'b1;
                        tx_state_d = TGAP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b1, shift_q[FRAME_W-1:1]};
                        dat_d   = shift_q[1];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            TGAP: begin
                if (div_q == DIV_W'(GAP - 1)) tx_state_d = TIDLE;
                else                          div_d      = div_q + DIV_W'(1);
            end
            default: tx_state_d = TIDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            w_state_q  <= WIDLE;
            r_state_q  <= RIDLE;
            tx_state_q <= TIDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '1;
            clk_q      <= 1'b1;
            dat_q      <= 1'b1;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'd0;
            bid_q      <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rid_q      <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            tx_state_q <= tx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            clk_q      <= clk_d;
            dat_q      <= dat_d;
            awready_q  <= (w_state_d == WIDLE);
            wready_q   <= (w_state_d == WDATA);
            bvalid_q   <= (w_state_d == WRESP);
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
            arready_q  <= (r_state_d == RIDLE);
            rvalid_q   <= (r_state_d == RDATA);
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
        end
    end

    // FIFO storage needs no reset; pointers and count define its contents.
    always_ff @(posedge clock) begin
        if (resetn && push) mem[wr_ptr_q] <= io_slave.wdata[7:0];
    end

    assign ps2_clk          = clk_q;
    assign ps2_dat          = dat_q;
    assign io_slave.awready = awready_q;
    assign io_slave.wready  = wready_q;
    assign io_slave.bvalid  = bvalid_q;
    assign io_slave.bresp   = bresp_q;
    assign io_slave.bid     = bid_q;
    assign io_slave.arready = arready_q;
    assign io_slave.rvalid  = rvalid_q;
    assign io_slave.rlast   = rvalid_q;
    assign io_slave.rdata   = rdata_q;
    assign io_slave.rresp   = 2'd0;
    assign io_slave.rid     = rid_q;

    logic unused_inputs;
    assign unused_inputs = ^{io_slave.awaddr, io_slave.awlen, io_slave.awsize, io_slave.awburst,
                             io_slave.araddr, io_slave.arlen, io_slave.arsize, io_slave.arburst,
                             io_slave.wdata[63:8], io_slave.wstrb[7:1], io_slave.wlast};
endmodule
